// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register with operand forwarding
// and load-use stall detection resolved in ID.
module id_exe_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              wreg,
  input  logic              m2reg,
  input  logic              wmem,
  input  logic              aluimm,
  input  logic              regrt,
  input  logic [3:0]        aluc,
  input  logic [RA_W-1:0]   rs,
  input  logic [RA_W-1:0]   rt,
  input  logic [RA_W-1:0]   rd,
  input  logic [DATA_W-1:0] qa,
  input  logic [DATA_W-1:0] qb,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] ealu,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic [RA_W-1:0]   mwn,
  input  logic [DATA_W-1:0] malu,
  input  logic [DATA_W-1:0] mmo,
  output logic              stall,
  output logic              ewreg,
  output logic              em2reg,
  output logic              ewmem,
  output logic              ealuimm,
  output logic [3:0]        ealuc,
  output logic [RA_W-1:0]   ewn,
  output logic [DATA_W-1:0] ea,
  output logic [DATA_W-1:0] eb,
  output logic [DATA_W-1:0] eimm
);

  logic [RA_W-1:0]   wn;
  logic              rt_use;
  logic              e_a, e_b;
  logic              m_a, m_b;
  logic              load;
  logic [DATA_W-1:0] fa, fb;

  assign wn     = regrt ? rt : rd;
  assign rt_use = id_valid & (~aluimm | wmem);

  // r0 is never a producer, so a zero destination kills every match
  assign e_a = ewreg & (ewn != '0) & (ewn == rs);
  assign e_b = ewreg & (ewn != '0) & (ewn == rt);
  assign m_a = mwreg & (mwn != '0) & (mwn == rs);
  assign m_b = mwreg & (mwn != '0) & (mwn == rt);

  assign stall = id_valid & em2reg
               & (e_a | (rt_use & e_b));

  assign load = id_valid & ~stall;

  // EXE is the younger writer and takes priority over MEM
  always_comb begin
    fa = qa;
    if (e_a && !em2reg) begin
      fa = ealu;
    end else if (m_a) begin
      fa = mm2reg ? mmo : malu;
    end
  end

  always_comb begin
    fb = qb;
    if (e_b && !em2reg) begin
      fb = ealu;
    end else if (m_b) begin
      fb = mm2reg ? mmo : malu;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !load) begin
      ewreg   <= 1'b0;
      em2reg  <= 1'b0;
      ewmem   <= 1'b0;
      ealuimm <= 1'b0;
      ealuc   <= 4'b0000;
      ewn     <= '0;
      ea      <= '0;
      eb      <= '0;
      eimm    <= '0;
    end else begin
      ewreg   <= wreg;
      em2reg  <= m2reg;
      ewmem   <= wmem;
      ealuimm <= aluimm;
      ealuc   <= aluc;
      ewn     <= wn;
      ea      <= fa;
      eb      <= fb;
      eimm    <= imm;
    end
  end

endmodule

// File: tb/tb_id_exe_stage.sv
// Scoreboard bench for id_exe_stage: expected E outputs
// are queued at drive time and compared after the edge.
module tb_id_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        wreg, m2reg, wmem, aluimm, regrt;
  logic [3:0]  aluc;
  logic [4:0]  rs, rt, rd;
  logic [31:0] qa, qb, imm;
  logic [31:0] ealu;
  logic        mwreg, mm2reg;
  logic [4:0]  mwn;
  logic [31:0] malu, mmo;
  logic        stall;
  logic        ewreg, em2reg, ewmem, ealuimm;
  logic [3:0]  ealuc;
  logic [4:0]  ewn;
  logic [31:0] ea, eb, eimm;

  typedef struct {
    logic        wreg, m2reg, wmem, aluimm;
    logic [3:0]  aluc;
    logic [4:0]  wn;
    logic [31:0] a, b, imm;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   vec    = 0;

  always #5 clk = ~clk;

  id_exe_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .wreg(wreg), .m2reg(m2reg), .wmem(wmem),
    .aluimm(aluimm), .regrt(regrt), .aluc(aluc),
    .rs(rs), .rt(rt), .rd(rd),
    .qa(qa), .qb(qb), .imm(imm), .ealu(ealu),
    .mwreg(mwreg), .mm2reg(mm2reg), .mwn(mwn),
    .malu(malu), .mmo(mmo), .stall(stall),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ealuimm(ealuimm), .ealuc(ealuc), .ewn(ewn),
    .ea(ea), .eb(eb), .eimm(eimm)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic set_id(
    input logic v, input logic w, input logic m2,
    input logic wm, input logic ai, input logic rr,
    input logic [3:0] c, input logic [4:0] s,
    input logic [4:0] t, input logic [4:0] d,
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] i);
    id_valid = v; wreg = w; m2reg = m2; wmem = wm;
    aluimm = ai; regrt = rr; aluc = c;
    rs = s; rt = t; rd = d; qa = a; qb = b; imm = i;
  endtask

  task automatic set_fw(
    input logic [31:0] ex, input logic mw,
    input logic mm, input logic [4:0] mn,
    input logic [31:0] ma, input logic [31:0] mo);
    ealu = ex; mwreg = mw; mm2reg = mm; mwn = mn;
    malu = ma; mmo = mo;
  endtask

  task automatic pop_cmp();
    exp_t e;
    string p;
    if (q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = q.pop_front();
    p = $sformatf("v%0d.", vec);
    chk({p, "ewreg"},   {31'd0, ewreg},   {31'd0, e.wreg});
    chk({p, "em2reg"},  {31'd0, em2reg},  {31'd0, e.m2reg});
    chk({p, "ewmem"},   {31'd0, ewmem},   {31'd0, e.wmem});
    chk({p, "ealuimm"}, {31'd0, ealuimm}, {31'd0, e.aluimm});
    chk({p, "ealuc"},   {28'd0, ealuc},   {28'd0, e.aluc});
    chk({p, "ewn"},     {27'd0, ewn},     {27'd0, e.wn});
    chk({p, "ea"},      ea,               e.a);
    chk({p, "eb"},      eb,               e.b);
    chk({p, "eimm"},    eimm,             e.imm);
  endtask

  // inputs must already be set; called right after a negedge
  task automatic step(
    input logic st, input logic w, input logic m2,
    input logic wm, input logic ai,
    input logic [3:0] c, input logic [4:0] n,
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] i);
    exp_t e;
    #1;
    chk($sformatf("v%0d.stall", vec),
        {31'd0, stall}, {31'd0, st});
    e.wreg = w; e.m2reg = m2; e.wmem = wm;
    e.aluimm = ai; e.aluc = c; e.wn = n;
    e.a = a; e.b = b; e.imm = i;
    q.push_back(e);
    @(posedge clk);
    #1;
    pop_cmp();
    vec++;
    @(negedge clk);
  endtask

  task automatic bubble(input logic st);
    step(st, 0, 0, 0, 0, 4'h0, 5'd0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with arbitrary live inputs
    rst = 1'b1;
    set_id(1, 1, 1, 1, 1, 0, 4'hf, 5'd1, 5'd2, 5'd3,
           32'hdead, 32'hbeef, 32'h77);
    set_fw(32'h1, 1, 0, 5'd1, 32'h2, 32'h3);
    @(posedge clk);
    @(negedge clk);
    bubble(1'b0);
    rst = 1'b0;
    set_fw(32'h0, 0, 0, 5'd0, 32'h0, 32'h0);

    // plain add r3 = r1 + r2
    set_id(1, 1, 0, 0, 0, 0, 4'b0010, 5'd1, 5'd2, 5'd3,
           32'd5, 32'd7, 32'h1234);
    step(0, 1, 0, 0, 0, 4'b0010, 5'd3, 32'd5, 32'd7,
         32'h1234);

    // sub r6 = r3 - r2, r3 from EXE
    set_fw(32'h10, 0, 0, 5'd0, 32'h0, 32'h0);
    set_id(1, 1, 0, 0, 0, 0, 4'b0110, 5'd3, 5'd2, 5'd6,
           32'd99, 32'd7, 32'h0);
    step(0, 1, 0, 0, 0, 4'b0110, 5'd6, 32'h10, 32'd7, 0);

    // lw r4, 8(r9)
    set_id(1, 1, 1, 0, 1, 1, 4'b0010, 5'd9, 5'd4, 5'd0,
           32'd100, 32'd55, 32'd8);
    step(0, 1, 1, 0, 1, 4'b0010, 5'd4, 32'd100, 32'd55,
         32'd8);

    // add r7 = r4 + r2: load-use, stall beats MEM forward
    set_fw(32'h0, 1, 0, 5'd2, 32'h99, 32'h0);
    set_id(1, 1, 0, 0, 0, 0, 4'b0010, 5'd4, 5'd2, 5'd7,
           32'd1, 32'd7, 32'h0);
    bubble(1'b1);

    // load now in MEM, value via mmo
    set_fw(32'h0, 1, 1, 5'd4, 32'h0, 32'hab);
    step(0, 1, 0, 0, 0, 4'b0010, 5'd7, 32'hab, 32'd7, 0);

    // lw r4 again, then lw r4, 4(r9): rt is dest only
    set_fw(32'h0, 0, 0, 5'd0, 32'h0, 32'h0);
    set_id(1, 1, 1, 0, 1, 1, 4'b0010, 5'd9, 5'd4, 5'd0,
           32'd100, 32'd55, 32'd8);
    step(0, 1, 1, 0, 1, 4'b0010, 5'd4, 32'd100, 32'd55,
         32'd8);
    set_id(1, 1, 1, 0, 1, 1, 4'b0010, 5'd9, 5'd4, 5'd0,
           32'd200, 32'd66, 32'd4);
    step(0, 1, 1, 0, 1, 4'b0010, 5'd4, 32'd200, 32'd66,
         32'd4);

    // sw r4 reads rt: load-use stall
    set_id(1, 0, 0, 1, 1, 1, 4'b0010, 5'd9, 5'd4, 5'd0,
           32'd200, 32'd66, 32'd4);
    bubble(1'b1);

    // id_valid=0 with X control bits
    set_id(0, 1'bx, 1'bx, 0, 0, 1'bx, 4'bx, 5'd1, 5'd2,
           5'd3, 32'd1, 32'd2, 32'd3);
    bubble(1'b0);

    // add r5 = r1 + r2
    set_id(1, 1, 0, 0, 0, 0, 4'b0010, 5'd1, 5'd2, 5'd5,
           32'd1, 32'd2, 32'h0);
    step(0, 1, 0, 0, 0, 4'b0010, 5'd5, 32'd1, 32'd2, 0);

    // EXE and MEM both write r5: EXE wins
    set_fw(32'h1, 1, 0, 5'd5, 32'h2, 32'h0);
    set_id(1, 1, 0, 0, 0, 0, 4'b0010, 5'd5, 5'd5, 5'd8,
           32'd77, 32'd88, 32'h0);
    step(0, 1, 0, 0, 0, 4'b0010, 5'd8, 32'd1, 32'd1, 0);

    // MEM-only ALU forward on A
    set_id(1, 1, 0, 0, 0, 0, 4'b0010, 5'd5, 5'd3, 5'd10,
           32'd77, 32'd9, 32'h0);
    step(0, 1, 0, 0, 0, 4'b0010, 5'd10, 32'd2, 32'd9, 0);

    // add r0 in EXE, MEM targets r0: no forwarding
    set_fw(32'h0, 0, 0, 5'd0, 32'h0, 32'h0);
    set_id(1, 1, 0, 0, 0, 0, 4'b0010, 5'd1, 5'd2, 5'd0,
           32'd3, 32'd4, 32'h0);
    step(0, 1, 0, 0, 0, 4'b0010, 5'd0, 32'd3, 32'd4, 0);
    set_fw(32'h1, 1, 0, 5'd0, 32'h2, 32'h0);
    set_id(1, 1, 0, 0, 0, 0, 4'b0010, 5'd0, 5'd0, 5'd11,
           32'h55, 32'h66, 32'h0);
    step(0, 1, 0, 0, 0, 4'b0010, 5'd11, 32'h55, 32'h66, 0);

    // lw r0 in EXE never stalls
    set_fw(32'h0, 0, 0, 5'd0, 32'h0, 32'h0);
    set_id(1, 1, 1, 0, 1, 1, 4'b0010, 5'd1, 5'd0, 5'd0,
           32'd3, 32'd0, 32'h0);
    step(0, 1, 1, 0, 1, 4'b0010, 5'd0, 32'd3, 32'd0, 0);
    set_id(1, 1, 0, 0, 0, 0, 4'b0010, 5'd0, 5'd0, 5'd12,
           32'd5, 32'd6, 32'h0);
    step(0, 1, 0, 0, 0, 4'b0010, 5'd12, 32'd5, 32'd6, 0);

    // reset during a load-use stall
    set_id(1, 1, 1, 0, 1, 1, 4'b0010, 5'd9, 5'd4, 5'd0,
           32'd100, 32'd55, 32'd8);
    step(0, 1, 1, 0, 1, 4'b0010, 5'd4, 32'd100, 32'd55,
         32'd8);
    set_id(1, 1, 0, 0, 0, 0, 4'b0010, 5'd4, 5'd2, 5'd7,
           32'd1, 32'd7, 32'h0);
    rst = 1'b1;
    bubble(1'b1);
    rst = 1'b0;
    step(0, 1, 0, 0, 0, 4'b0010, 5'd7, 32'd1, 32'd7, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_exe_stage.md
Name: id_exe_stage

Overview:
- Decode-to-execute pipeline stage sitting directly downstream of the instruction decoder's control unit.
- Captures the decoder control word (wreg, m2reg, wmem, aluimm, regrt, aluc), register operands and sign-extended immediate into the ID/EXE pipeline register.
- Resolves data hazards in the ID stage: forwards EXE/MEM results into operands and detects load-use hazards, issuing a one-cycle stall with a bubble into EXE.

Parameters:
- DATA_W, 32, operand/immediate width
- RA_W, 5, register address width

Ports:
- clk in 1: rising-edge clock
- rst in 1: synchronous, active-high reset
- id_valid in 1: ID holds a real instruction; 0 = treat as bubble
- wreg, m2reg, wmem, aluimm, regrt in 1 each: decoder control bits
- aluc in 4: decoder ALU control
- rs, rt, rd in RA_W: instruction register fields
- qa, qb in DATA_W: register file read data for rs, rt
- imm in DATA_W: sign-extended immediate
- ealu in DATA_W: ALU result currently in EXE
- mwreg, mm2reg in 1: MEM-stage write-enable, load flag
- mwn in RA_W: MEM-stage destination
- malu, mmo in DATA_W: MEM-stage ALU result, memory read data
- stall out 1: combinational; freezes PC and IF/ID when 1
- ewreg, em2reg, ewmem, ealuimm out 1 each: registered control
- ealuc out 4: registered ALU control
- ewn out RA_W: registered destination (rt if regrt else rd)
- ea, eb, eimm out DATA_W: registered operands, immediate

Behaviour:
- Reset: on rising clk with rst=1 all registered outputs become 0 (ewreg, em2reg, ewmem, ealuimm, ealuc=4'b0000, ewn, ea, eb, eimm). rst overrides stall and id_valid.
- Destination: wn = regrt ? rt : rd, computed in ID, registered to ewn.
- Register 0 is never a hazard or forwarding source: any comparison against destination 0 is false.
- Operand use: rs used whenever id_valid. rt used when id_valid and (aluimm=0 or wmem=1).
- Load-use hazard: stall = id_valid & ewreg & em2reg & ewn!=0 & ((ewn==rs) | (rt used & ewn==rt)). Purely combinational, no registered delay.
- Forwarding for A (rs), priority order, first match wins:
  - ewreg & ~em2reg & ewn==rs, ewn!=0 -> ealu
  - mwreg & ~mm2reg & mwn==rs, mwn!=0 -> malu
  - mwreg & mm2reg & mwn==rs, mwn!=0 -> mmo
  - otherwise qa
- Forwarding for B (rt): same priority and rules with rt and qb. The forwarded value feeds eb regardless of aluimm; EXE muxes eimm.
- Clocked update, rst=0:
  - stall=1 or id_valid=0: bubble. ewreg, em2reg, ewmem, ealuimm, ealuc, ewn cleared to 0; ea/eb/eimm don't-care, implemented as 0.
  - Otherwise: all E outputs load the ID values and forwarded operands in the same cycle.
- Latency: 1 cycle ID->EXE. A stall lasts exactly 1 cycle per load-use pair, because the bubble clears em2reg and the hazard then resolves by MEM forwarding of mmo.
- Simultaneous EXE and MEM match on the same register: EXE wins, as the younger writer.
- Stall with concurrent MEM forwarding: stall wins; nothing is latched except the bubble.
- Reset mid-stall: the next edge clears everything and stall deasserts unless the hazard condition recurs from live inputs.
- Control bits wreg/m2reg/regrt from a decoder that does not drive them for unknown opcodes: id_valid must be 0 for those. With id_valid=0 no X reaches E outputs.

Test Plan:
- Reset: drive rst=1 one edge with arbitrary inputs -> all E outputs 0, ealuc=0000, stall=0.
- Plain add: rs=1 qa=5, rt=2 qb=7, rd=3, wreg=1 regrt=0 aluc=0010, no hazards -> next edge ewreg=1 ewn=3 ea=5 eb=7 ealuc=0010.
- EXE forward: prior add writing r3 in EXE, ealu=32'h10; current sub with rs=3 -> stall=0, ea=32'h10 next edge, ealuc=0110.
- Load-use: lw r4 in EXE (ewreg=1 em2reg=1 ewn=4); current add rs=4 -> stall=1, next edge ewreg=0 bubble. Then with mwn=4 mm2reg=1 mmo=32'hAB -> stall=0, ea=32'hAB.
- lw base only: current lw with rt=4 aluimm=1 wmem=0, rs=9, EXE load to r4 -> stall=0, ewn=4, ealuimm=1.
- r0 and priority: EXE and MEM both target r5, ealu=1 malu=2, rs=5 -> ea=1. Repeat with targets r0, rs=0 -> ea=qa, stall=0.
